// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, default width and result bundle types for the ALU execute stage
//
// Purpose: opcode encodings, default datapath width, flag and result bundle types.
// Ports: none (package).
package alu_pkg;

    localparam int ALU_N = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LAST = OP_SRA;

    typedef struct packed {
        logic zero;
        logic cout;
        logic ovf;
        logic err;
    } alu_flags_t;

    // Full result bundle at the default width.
    typedef struct packed {
        logic [ALU_N-1:0] result;
        logic             zero;
        logic             cout;
        logic             ovf;
        logic             err;
    } alu_bundle_t;

endpackage

// File: rtl/alu_core_comb.sv
// rtl/alu_core_comb.sv - combinational ALU datapath producing result and flags
//
// Purpose: one-cycle ALU function of (a, b, op).
// Ports:
//   a, b    in  [N-1:0]  operands (b[SHW-1:0] is the shift amount)
//   op      in  [3:0]    opcode
//   result  out [N-1:0]  ALU result
//   flags   out          {zero, cout, ovf, err}
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int N   = ALU_N,
    parameter int SHW = $clog2(N)
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic [N-1:0] result,
    output alu_flags_t   flags
);

    logic           is_sub;
    logic [N-1:0]   b_eff;
    logic [N:0]     sum;
    logic [SHW-1:0] shamt;

    // SUB reuses the adder as a + ~b + 1, so cout becomes "no borrow".
    assign is_sub = (op == OP_SUB);
    assign b_eff  = is_sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
    assign shamt  = b[SHW-1:0];

    always_comb begin
        result     = '0;
        flags      = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                result     = sum[N-1:0];
                flags.cout = sum[N];
                flags.ovf  = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_SLT:  result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(N-1){1'b0}}, (a < b)};
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $signed(a) >>> shamt;
            default: flags.err = 1'b1;
        endcase
        flags.zero = (result == '0);
    end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - registered ALU execute stage with output register and one-entry skid buffer
//
// Purpose: accept a/b/op with valid/ready, present result and flags one cycle later,
// absorbing one extra op in a skid register under downstream backpressure.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    upstream handshake (in_ready = !skid_valid)
//   a, b, op              operands and opcode
//   out_valid, out_ready  downstream handshake
//   result, zero, cout, ovf, err  registered result and flags
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int N   = ALU_N,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         cout,
    output logic         ovf,
    output logic         err
);

    logic [N-1:0] core_result;
    alu_flags_t   core_flags;

    logic [N-1:0] out_result;
    alu_flags_t   out_flags;
    logic         skid_valid;
    logic [N-1:0] skid_result;
    alu_flags_t   skid_flags;

    logic accept;
    logic out_free;

    alu_core_comb #(
        .N   (N),
        .SHW (SHW)
    ) u_core (
        .a      (a),
        .b      (b),
        .op     (op),
        .result (core_result),
        .flags  (core_flags)
    );

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    // Output register can take new data this edge: empty or being drained.
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_flags   <= '0;
            skid_valid  <= 1'b0;
            skid_result <= '0;
            skid_flags  <= '0;
        end else if (out_free) begin
            // The skid entry is older than anything upstream, so it goes first;
            // in_ready is low whenever skid is full, so no accept competes here.
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_result <= skid_result;
                out_flags  <= skid_flags;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_result <= core_result;
                out_flags  <= core_flags;
            end else begin
                out_valid  <= 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the new op in the skid register.
            skid_valid  <= 1'b1;
            skid_result <= core_result;
            skid_flags  <= core_flags;
        end
    end

    assign result = out_result;
    assign zero   = out_flags.zero;
    assign cout   = out_flags.cout;
    assign ovf    = out_flags.ovf;
    assign err    = out_flags.err;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - self-checking bench for alu_exec_stage
module tb_alu_exec_stage;

    localparam int N = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] result;
    logic         zero, cout, ovf, err;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .cout      (cout),
        .ovf       (ovf),
        .err       (err)
    );

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        v;
        logic        e;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic exp_t dut_bundle();
        exp_t x;
        x.r = result; x.z = zero; x.c = cout; x.v = ovf; x.e = err;
        return x;
    endfunction

    // Reference: computed from the arithmetic meaning of each opcode.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t   m;
        longint sx, sy, sr;
        logic [32:0] w;
        int     sh;
        m  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y % 32);
        case (o)
            4'd0: begin
                w = {1'b0, x} + {1'b0, y};
                m.r = w[31:0]; m.c = w[32];
                sr = sx + sy; m.v = (sr > SMAX) || (sr < SMIN);
            end
            4'd1: begin
                m.r = x - y; m.c = (x >= y);
                sr = sx - sy; m.v = (sr > SMAX) || (sr < SMIN);
            end
            4'd2: m.r = x & y;
            4'd3: m.r = x | y;
            4'd4: m.r = x ^ y;
            4'd5: m.r = ~(x | y);
            4'd6: m.r = (sx < sy) ? 32'd1 : 32'd0;
            4'd7: m.r = (x < y) ? 32'd1 : 32'd0;
            4'd8: m.r = x << sh;
            4'd9: m.r = x >> sh;
            4'd10: m.r = 32'(sx >>> sh);
            default: m.e = 1'b1;
        endcase
        m.z = (m.r == 32'd0);
        return m;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    vec_t vt[15];
    exp_t q[$];

    initial begin
        vt[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, '{32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0}};
        vt[1]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, '{32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0}};
        vt[2]  = '{4'd1,  32'h00000005, 32'h00000005, '{32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0}};
        vt[3]  = '{4'd1,  32'h00000000, 32'h00000001, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[4]  = '{4'd1,  32'h80000000, 32'h00000001, '{32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0}};
        vt[5]  = '{4'd6,  32'hFFFFFFFF, 32'h00000001, '{32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[6]  = '{4'd7,  32'hFFFFFFFF, 32'h00000001, '{32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0}};
        vt[7]  = '{4'd10, 32'h80000000, 32'h00000004, '{32'hF8000000, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[8]  = '{4'd9,  32'h80000000, 32'h00000004, '{32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[9]  = '{4'd8,  32'h00000001, 32'h00000021, '{32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[10] = '{4'd5,  32'h00000000, 32'h00000000, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[11] = '{4'd4,  32'hA5A5A5A5, 32'hA5A5A5A5, '{32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0}};
        vt[12] = '{4'hF,  32'h00001234, 32'h00001234, '{32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1}};
        vt[13] = '{4'd2,  32'hFF00FF00, 32'h0F0F0F0F, '{32'h0F000F00, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[14] = '{4'd3,  32'h00000001, 32'h00000002, '{32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0}};

        // Reset state
        #12;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_bundle", 64'(dut_bundle()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, back to back with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            send(vt[i].op, vt[i].a, vt[i].b);
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_bundle", i), 64'(dut_bundle()), 64'(vt[i].exp));
        end
        @(posedge clk); #1;
        check("drain_empty", 64'(out_valid), 64'd0);

        // Backpressure: two ops stall, third presented while full is ignored
        out_ready = 1'b0;
        send(4'd0, 32'd1, 32'd1);
        check("bp_first_valid", 64'(out_valid), 64'd1);
        check("bp_first_ready", 64'(in_ready), 64'd1);
        send(4'd0, 32'd2, 32'd2);
        check("bp_full_ready", 64'(in_ready), 64'd0);
        check("bp_hold_result", 64'(result), 64'd2);
        @(negedge clk);
        op = 4'd0; a = 32'd9; b = 32'd9; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_result2", 64'(result), 64'd2);
        check("bp_hold_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_present_first", 64'(result), 64'd2);
        @(posedge clk); #1;
        check("bp_second_result", 64'(result), 64'd4);
        check("bp_second_valid", 64'(out_valid), 64'd1);
        check("bp_ready_after_drain", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        check("bp_empty", 64'(out_valid), 64'd0);

        // Reset with both registers full
        out_ready = 1'b0;
        send(4'd2, 32'hFFFF, 32'hFF);
        send(4'd3, 32'h1, 32'h2);
        check("rst_pre_full", 64'(in_ready), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_ready", 64'(in_ready), 64'd1);
        check("rst_mid_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_output", 64'(out_valid), 64'd0);

        // Randomized traffic against the queue model
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            op = 4'($urandom_range(0, 15));
            a  = pick_operand();
            b  = pick_operand();
            #1;
            check("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
            if (out_valid && out_ready && q.size() > 0) begin
                check($sformatf("rnd_bundle_c%0d", cyc), 64'(dut_bundle()), 64'(q[0]));
                void'(q.pop_front());
            end
            if (in_valid && in_ready)
                q.push_back(model(op, a, b));
        end
        @(negedge clk);
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
